// File: rtl/ej32_obuf_reader.sv
// Purpose: drains the eJ32 output buffer at OBUF onto a byte valid/ready stream.
// Latency: 3 cycles per byte with grant and ready held high: REQ/RD, WAIT, SEND.
// Backpressure: holds tx_data while !tx_ready and drops mem_req so the core can use the bus.
//
// Ports: clk, rst (synchronous, active-high); start/len start a transfer (ignored unless idle);
//        mem_req/mem_gnt/mem_rd/mem_a/mem_d form the byte-wide memory read port
//        (mem_d arrives one cycle after mem_rd); tx_data/tx_valid/tx_ready is the output
//        stream; busy, done and count report transfer status.
module ej32_obuf_reader #(
    parameter int          ASZ   = 17,
    parameter int unsigned OBUF  = 'h1400,
    parameter int          LSZ   = 10,
    parameter bit          STOPZ = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LSZ-1:0] len,
    output logic           mem_req,
    input  logic           mem_gnt,
    output logic [ASZ-1:0] mem_a,
    output logic           mem_rd,
    input  logic [7:0]     mem_d,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           busy,
    output logic           done,
    output logic [LSZ-1:0] count
);

    // RD names the cycle in which REQ sees the grant and strobes the read.
    // That cycle stays in REQ and leaves directly for WAIT, so RD is never
    // registered; it only has a defensive arc to WAIT.
    typedef enum logic [2:0] {IDLE, REQ, RD, WAIT, SEND, FIN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [ASZ-1:0] ptr;
    logic [LSZ-1:0] rem;
    logic [7:0]     data_q;
    logic [LSZ-1:0] cnt_q;

    // The pointer doubles as the address bus; it is only meaningful while mem_rd is high.
    assign mem_a   = ptr;
    assign tx_data = data_q;
    assign count   = cnt_q;

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_rd    = 1'b0;
        tx_valid  = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len == '0) ? FIN : REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    mem_rd    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            RD: begin
                mem_req   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Bus is held until the data lands; a grant drop here is irrelevant.
                mem_req = 1'b1;
                if (STOPZ && (mem_d == 8'h00)) begin
                    state_nxt = FIN;
                end else begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_nxt = (rem == '0) ? FIN : REQ;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            rem    <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr   <= ASZ'(OBUF);
                        rem   <= len;
                        cnt_q <= '0;
                    end
                end
                WAIT: begin
                    // A terminating NUL is captured too, but it is never presented.
                    data_q <= mem_d;
                    ptr    <= ptr + ASZ'(1);
                    rem    <= rem - LSZ'(1);
                end
                SEND: begin
                    if (tx_ready) begin
                        cnt_q <= cnt_q + LSZ'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ej32_obuf_reader.sv
// Purpose: randomized scoreboard bench for ej32_obuf_reader with a queue-based reference model.
// Latency: expected done edge is derived from the byte count and NUL position when grant/ready are held high.
// Backpressure: ready stalls and grant gaps are generated by a driver process; a monitor checks the protocol.
module tb_ej32_obuf_reader;

    localparam int          ASZ  = 17;
    localparam int          LSZ  = 10;
    localparam int unsigned OBUF = 'h1400;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [LSZ-1:0] len = '0;
    logic           mem_req;
    logic           mem_gnt = 1'b0;
    logic [ASZ-1:0] mem_a;
    logic           mem_rd;
    logic [7:0]     mem_d = 8'h00;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b0;
    logic           busy;
    logic           done;
    logic [LSZ-1:0] count;

    always #5 clk = ~clk;

    ej32_obuf_reader #(.ASZ(ASZ), .OBUF(OBUF), .LSZ(LSZ), .STOPZ(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_rd(mem_rd), .mem_d(mem_d),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .count(count)
    );

    // Byte memory: registered read, data one cycle after the strobe.
    logic [7:0] mem [0:(1<<ASZ)-1];
    always @(posedge clk) if (mem_rd) mem_d <= mem[mem_a];

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct packed {
        int cnt;
        int dedge;
        bit timed;
    } done_t;

    logic [7:0]     exp_byte_q[$];
    logic [ASZ-1:0] exp_addr_q[$];
    done_t          exp_done_q[$];

    int n_vec = 0;
    int n_mis = 0;
    int gnt_mode = 0;   // 0 always, 1 one-of-three, 2 random, 3 never
    int rdy_mode = 0;   // 0 always, 1 random, 2 stall on second byte
    int hs_total = 0;
    int hs_base = 0;
    bit end_req = 0;
    bit mon_done = 0;

    // Input driver for grant and ready, one time unit after the active edge.
    int stall_left = 5;
    always @(posedge clk) begin
        #1;
        case (gnt_mode)
            0: mem_gnt = 1'b1;
            1: mem_gnt = (ecnt % 3 == 0);
            2: mem_gnt = 1'($urandom_range(0, 1));
            default: mem_gnt = 1'b0;
        endcase
        if (rdy_mode == 2) begin
            if (tx_valid && (hs_total - hs_base == 1) && stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else begin
                tx_ready = 1'b1;
            end
        end else begin
            stall_left = 5;
            if (rdy_mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
            else               tx_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_mis++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, a byte or a done pulse.
    bit         rst_prev = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    int         run_cnt = 0;
    int         busy_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (rst_prev) begin
                chk("rst_mem_req", mem_req, 0);
                chk("rst_mem_rd", mem_rd, 0);
                chk("rst_mem_a", mem_a, 0);
                chk("rst_tx_valid", tx_valid, 0);
                chk("rst_tx_data", tx_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_count", count, 0);
            end
            exp_byte_q.delete();
            exp_addr_q.delete();
            exp_done_q.delete();
            prev_stall = 0;
            run_cnt = 0;
            busy_run = 0;
            rst_prev = 1;
        end else begin
            rst_prev = 0;
            if (mem_rd) begin
                chk("rd_gnt", mem_gnt, 1);
                chk("rd_req", mem_req, 1);
                if (exp_addr_q.size() == 0) fail("unexpected_mem_rd");
                else chk("mem_a", mem_a, exp_addr_q.pop_front());
            end
            if (tx_valid) chk("req_during_send", mem_req, 0);
            if (prev_stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_byte_q.size() == 0) fail("unexpected_tx_byte");
                else chk("tx_data", tx_data, exp_byte_q.pop_front());
                chk("count_run", count, run_cnt);
                run_cnt++;
                hs_total++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    done_t d;
                    d = exp_done_q.pop_front();
                    chk("done_count", count, d.cnt);
                    chk("done_busy", busy, 1);
                    chk("bytes_left_at_done", exp_byte_q.size(), 0);
                    if (d.timed) chk("done_cycle", ecnt, d.dedge);
                end
                run_cnt = 0;
            end
            if (busy) busy_run++;
            else      busy_run = 0;
            if (busy_run == 300) fail("watchdog_busy_stuck");
            if (end_req && !mon_done) begin
                chk("end_bytes_left", exp_byte_q.size(), 0);
                chk("end_addrs_left", exp_addr_q.size(), 0);
                chk("end_dones_left", exp_done_q.size(), 0);
                mon_done = 1;
            end
        end
    end

    // Reference model: the transfer is the byte string at OBUF, cut at len bytes
    // or at the first NUL, with three cycles per emitted byte and two for the NUL read.
    task automatic push_expect(input int n, input bit timed, input int s_edge);
        int    e = 0;
        bit    nul = 0;
        done_t d;
        for (int i = 0; i < n; i++) begin
            logic [ASZ-1:0] a;
            a = ASZ'((OBUF + i) % (1 << ASZ));
            exp_addr_q.push_back(a);
            if (mem[a] == 8'h00) begin
                nul = 1;
                break;
            end
            exp_byte_q.push_back(mem[a]);
            e++;
        end
        d.cnt   = e;
        d.dedge = s_edge + 3 * e + (nul ? 2 : 0);
        d.timed = timed;
        exp_done_q.push_back(d);
    endtask

    // Called one time unit after an active edge with the DUT idle.
    task automatic run(input int n, input bit timed, input bit poke);
        push_expect(n, timed, ecnt + 1);
        hs_base = hs_total;
        start = 1'b1;
        len   = LSZ'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1;
            len   = LSZ'(2);
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic load_rand(input int n, input int zero_pct);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 99) < zero_pct) b = 8'h00;
            mem[ASZ'(OBUF + i)] = b;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // "ok\r\n", both handshakes always high.
        mem[ASZ'(OBUF + 0)] = 8'h6F;
        mem[ASZ'(OBUF + 1)] = 8'h6B;
        mem[ASZ'(OBUF + 2)] = 8'h0D;
        mem[ASZ'(OBUF + 3)] = 8'h0A;
        mem[ASZ'(OBUF + 4)] = 8'h55;
        run(4, 1, 0);

        // NUL terminator cuts a longer request short.
        mem[ASZ'(OBUF + 0)] = 8'h68;
        mem[ASZ'(OBUF + 1)] = 8'h69;
        mem[ASZ'(OBUF + 2)] = 8'h00;
        mem[ASZ'(OBUF + 3)] = 8'h78;
        run(10, 1, 0);

        // Empty transfer.
        run(0, 1, 0);

        // Start while busy is ignored.
        load_rand(5, 0);
        run(5, 1, 1);

        // Consumer stall on the second byte.
        load_rand(5, 0);
        rdy_mode = 2;
        run(5, 0, 0);
        rdy_mode = 0;

        // Grant in one cycle of three.
        load_rand(6, 0);
        gnt_mode = 1;
        run(6, 0, 0);
        gnt_mode = 0;

        // Reset while the third byte is in flight, then a clean restart.
        load_rand(6, 0);
        push_expect(6, 0, ecnt + 1);
        start = 1'b1;
        len   = LSZ'(6);
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int rds = 0;
            for (int i = 0; i < 100 && rds < 3; i++) begin
                @(negedge clk);
                if (mem_rd) rds++;
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run(6, 1, 0);

        // Randomized traffic.
        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(0, 24);
            load_rand(n + 1, 10);
            gnt_mode = $urandom_range(0, 2);
            rdy_mode = $urandom_range(0, 1);
            run(n, 0, 0);
        end
        gnt_mode = 0;
        rdy_mode = 0;

        end_req = 1;
        for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
